// File: rtl/audio_dac_serializer.sv
// Left-justified stereo serializer for a codec DAC port.
// Generates BCLK/LRCK from Clk, holds one pending stereo sample and replays
// the previous frame (flagging underrun) when no new sample is available.
module audio_dac_serializer #(
    parameter int unsigned BCLK_HALF = 8,
    parameter int unsigned SLOT_BITS = 32
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [15:0] in_l,
    input  logic [15:0] in_r,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        frame_start,
    output logic        underrun,
    input  logic        clear_underrun,
    output logic        AUD_BCLK,
    output logic        AUD_DACLRCK,
    output logic        AUD_DACDAT
);

    localparam int unsigned DW = $clog2(BCLK_HALF);
    localparam int unsigned CW = $clog2(2 * SLOT_BITS);
    localparam logic [DW-1:0] DIV_MAX = DW'(BCLK_HALF - 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(2 * SLOT_BITS - 1);
    localparam logic [CW-1:0] SLOT_R  = CW'(SLOT_BITS);

    logic [DW-1:0] div;
    logic [CW-1:0] bit_cnt;
    logic [15:0]   buf_l, buf_r;
    logic [15:0]   last_l, last_r;
    logic [15:0]   sh_l, sh_r;
    logic          load_empty;

    logic [CW-1:0] next_cnt_c;
    logic          fall_c;
    logic          load_c;
    logic          xfer_c;
    logic [15:0]   src_l_c, src_r_c;

    // Bit-clock falling event, next slot position and frame source selection
    always_comb begin
        next_cnt_c = (bit_cnt == CNT_MAX) ? '0 : bit_cnt + CW'(1);
        fall_c     = (div == DIV_MAX) && AUD_BCLK;
        load_c     = fall_c && (next_cnt_c == '0);
        xfer_c     = in_valid && in_ready;
        src_l_c    = in_ready ? last_l : buf_l;
        src_r_c    = in_ready ? last_r : buf_r;
    end

    // Clock divider, slot sequencing, shift registers, holding buffer, underrun flag
    always_ff @(posedge Clk) begin
        if (Reset) begin
            div         <= '0;
            bit_cnt     <= CNT_MAX;
            AUD_BCLK    <= 1'b0;
            AUD_DACLRCK <= 1'b0;
            AUD_DACDAT  <= 1'b0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
            load_empty  <= 1'b0;
            in_ready    <= 1'b1;
            buf_l       <= '0;
            buf_r       <= '0;
            last_l      <= '0;
            last_r      <= '0;
            sh_l        <= '0;
            sh_r        <= '0;
        end else begin
            frame_start <= 1'b0;
            load_empty  <= 1'b0;

            if (div == DIV_MAX) begin
                div      <= '0;
                AUD_BCLK <= ~AUD_BCLK;
            end else begin
                div <= div + DW'(1);
            end

            if (fall_c) begin
                bit_cnt     <= next_cnt_c;
                AUD_DACLRCK <= (next_cnt_c < SLOT_R);
                if (next_cnt_c == '0) begin
                    frame_start <= 1'b1;
                    AUD_DACDAT  <= src_l_c[15];
                    sh_l        <= {src_l_c[14:0], 1'b0};
                    sh_r        <= src_r_c;
                    last_l      <= src_l_c;
                    last_r      <= src_r_c;
                    load_empty  <= in_ready;
                end else if (next_cnt_c < SLOT_R) begin
                    AUD_DACDAT <= sh_l[15];
                    sh_l       <= {sh_l[14:0], 1'b0};
                end else begin
                    AUD_DACDAT <= sh_r[15];
                    sh_r       <= {sh_r[14:0], 1'b0};
                end
            end

            // A full buffer drains at a load; a transfer can only happen while empty
            if (load_c && !in_ready) begin
                in_ready <= 1'b1;
            end
            if (xfer_c) begin
                in_ready <= 1'b0;
                buf_l    <= in_l;
                buf_r    <= in_r;
            end

            // Set has priority over clear
            if (load_empty) begin
                underrun <= 1'b1;
            end else if (clear_underrun) begin
                underrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_audio_dac_serializer.sv
// Randomized bench for audio_dac_serializer: two instances (16- and 32-bit
// slots) checked every cycle against a timeline model derived from frame arithmetic.
module tb_audio_dac_serializer;

    localparam int BH = 2;

    logic Clk   = 1'b0;
    logic Reset = 1'b1;
    logic [1:0][15:0] in_l_v, in_r_v;
    logic [1:0] in_valid_v, clr_v;
    logic [1:0] in_ready_v, fs_v, und_v, bclk_v, lrck_v, dat_v;

    always #5 Clk = ~Clk;

    audio_dac_serializer #(.BCLK_HALF(2), .SLOT_BITS(16)) dut0 (
        .Clk(Clk), .Reset(Reset), .in_l(in_l_v[0]), .in_r(in_r_v[0]),
        .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]), .frame_start(fs_v[0]),
        .underrun(und_v[0]), .clear_underrun(clr_v[0]), .AUD_BCLK(bclk_v[0]),
        .AUD_DACLRCK(lrck_v[0]), .AUD_DACDAT(dat_v[0])
    );

    audio_dac_serializer #(.BCLK_HALF(2), .SLOT_BITS(32)) dut1 (
        .Clk(Clk), .Reset(Reset), .in_l(in_l_v[1]), .in_r(in_r_v[1]),
        .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]), .frame_start(fs_v[1]),
        .underrun(und_v[1]), .clear_underrun(clr_v[1]), .AUD_BCLK(bclk_v[1]),
        .AUD_DACLRCK(lrck_v[1]), .AUD_DACDAT(dat_v[1])
    );

    int t;
    int n_chk  = 0;
    int n_pass = 0;
    int last_fs [2];

    // Reference model state: pending sample, last played frame, underrun flag
    logic        mfull [2];
    logic        mund  [2];
    logic        mpend [2];
    logic [15:0] mbl [2], mbr [2], mll [2], mlr [2];
    logic [15:0] frl [2][256];
    logic [15:0] frr [2][256];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, obs, exp, t);
    endtask

    function automatic int sb_of(input int i);
        return (i == 0) ? 16 : 32;
    endfunction

    // Loads occur on every 2*SLOT_BITS-th falling event, the first one at 2*BH cycles
    function automatic bit is_load(input int i, input int tt);
        int k;
        k = tt / (2 * BH);
        return (tt > 0) && ((tt % (2 * BH)) == 0) && (((k - 1) % (2 * sb_of(i))) == 0);
    endfunction

    function automatic int frame_of(input int i, input int tt);
        return (((tt / (2 * BH)) - 1) / (2 * sb_of(i))) % 256;
    endfunction

    task automatic model_step(input int i, input logic rst);
        bit xfer;
        int f;
        if (rst) begin
            mfull[i] = 1'b0; mund[i] = 1'b0; mpend[i] = 1'b0;
            mll[i] = '0; mlr[i] = '0; mbl[i] = '0; mbr[i] = '0;
        end else begin
            xfer = in_valid_v[i] && !mfull[i];
            if (mpend[i]) mund[i] = 1'b1;
            else if (clr_v[i]) mund[i] = 1'b0;
            mpend[i] = 1'b0;
            if (is_load(i, t)) begin
                f = frame_of(i, t);
                if (mfull[i]) begin
                    frl[i][f] = mbl[i]; frr[i][f] = mbr[i];
                    mll[i] = mbl[i]; mlr[i] = mbr[i];
                    mfull[i] = 1'b0;
                end else begin
                    frl[i][f] = mll[i]; frr[i][f] = mlr[i];
                    mpend[i] = 1'b1;
                end
            end
            if (xfer) begin
                mfull[i] = 1'b1; mbl[i] = in_l_v[i]; mbr[i] = in_r_v[i];
            end
        end
    endtask

    task automatic compare(input int i);
        int k, p, q, sb;
        logic elr, ed;
        logic [15:0] w;
        sb  = sb_of(i);
        k   = t / (2 * BH);
        elr = 1'b0;
        ed  = 1'b0;
        if (k > 0) begin
            p   = (k - 1) % (2 * sb);
            elr = (p < sb);
            q   = p % sb;
            w   = elr ? frl[i][frame_of(i, t)] : frr[i][frame_of(i, t)];
            if (q < 16) ed = w[15 - q];
        end
        check($sformatf("bclk%0d", i),     32'(bclk_v[i]),     32'((t / BH) % 2));
        check($sformatf("lrck%0d", i),     32'(lrck_v[i]),     32'(elr));
        check($sformatf("dacdat%0d", i),   32'(dat_v[i]),      32'(ed));
        check($sformatf("fstart%0d", i),   32'(fs_v[i]),       32'(is_load(i, t)));
        check($sformatf("underrun%0d", i), 32'(und_v[i]),      32'(mund[i]));
        check($sformatf("in_ready%0d", i), 32'(in_ready_v[i]), 32'(!mfull[i]));
    endtask

    // One Clk: advance the timeline, update model, compare both instances
    task automatic tick();
        @(posedge Clk);
        #1;
        if (Reset) t = 0;
        else t++;
        for (int i = 0; i < 2; i++) begin
            model_step(i, Reset);
            compare(i);
            if (Reset) begin
                last_fs[i] = -1;
            end else if (fs_v[i]) begin
                if (last_fs[i] >= 0)
                    check($sformatf("period%0d", i), 32'(t - last_fs[i]), 32'(4 * sb_of(i) * BH));
                last_fs[i] = t;
            end
        end
    endtask

    task automatic drive_rand(input int pv, input int pc);
        for (int i = 0; i < 2; i++) begin
            in_valid_v[i] = ($urandom_range(0, pv) == 0);
            in_l_v[i]     = 16'($urandom);
            in_r_v[i]     = 16'($urandom);
            clr_v[i]      = ($urandom_range(0, pc) == 0);
        end
    endtask

    task automatic idle();
        in_valid_v = '0;
        clr_v      = '0;
    endtask

    initial begin
        in_l_v = '0; in_r_v = '0; in_valid_v = '0; clr_v = '0;
        last_fs[0] = -1; last_fs[1] = -1;
        t = 0;

        Reset = 1'b1;
        tick();
        tick();
        Reset = 1'b0;

        // Known sample before the first load
        in_valid_v = 2'b11;
        in_l_v[0] = 16'hA5C3; in_r_v[0] = 16'h8001;
        in_l_v[1] = 16'h1234; in_r_v[1] = 16'hFEDC;
        tick();
        idle();

        // Starved frames replay the last sample and raise underrun
        for (int n = 0; n < 600; n++) tick();
        clr_v = 2'b11;
        tick();
        idle();
        for (int n = 0; n < 100; n++) tick();

        // Back-to-back writes with valid held high
        for (int n = 0; n < 700; n++) begin
            in_valid_v = 2'b11;
            in_l_v[0] = 16'($urandom); in_r_v[0] = 16'($urandom);
            in_l_v[1] = 16'($urandom); in_r_v[1] = 16'($urandom);
            clr_v = ($urandom_range(0, 50) == 0) ? 2'b11 : 2'b00;
            tick();
        end
        idle();

        for (int n = 0; n < 3000; n++) begin
            drive_rand(60, 150);
            tick();
        end

        // Reset during the 5th bit of the left slot, with a sample held in the buffer
        for (int n = 0; n < 300; n++) begin
            if ((t % 128) == 20) break;
            drive_rand(40, 1000);
            tick();
        end
        check("reset_align", 32'(t % 128), 32'd20);
        idle();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        for (int n = 0; n < 600; n++) tick();

        for (int n = 0; n < 1500; n++) begin
            drive_rand(80, 200);
            tick();
        end
        idle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/audio_dac_serializer.md
AUDIO_DAC_SERIALIZER -- requirements
Module: audio_dac_serializer

Interface
REQ-001 SHALL have parameter BCLK_HALF, default 8, Clk cycles per BCLK half-period (>=2).
REQ-002 SHALL have parameter SLOT_BITS, default 32, BCLK periods per channel slot (>=16).
REQ-003 SHALL have Clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have Reset  input  1  reset; synchronous, active-high.
REQ-005 SHALL have in_l  input  16  signed left sample, from the effect chain (delay output).
REQ-006 SHALL have in_r  input  16  signed right sample.
REQ-007 SHALL have in_valid  input  1  in_l/in_r valid.
REQ-008 SHALL have in_ready  output  1  holding buffer empty; a transfer occurs when in_valid && in_ready.
REQ-009 SHALL have frame_start  output  1  one-Clk pulse per frame load; usable as upstream sample-rate Enable.
REQ-010 SHALL have underrun  output  1  sticky, set when a frame loads with the buffer empty.
REQ-011 SHALL have clear_underrun  input  1  clears underrun.
REQ-012 SHALL have AUD_BCLK  output  1  codec bit clock.
REQ-013 SHALL have AUD_DACLRCK  output  1  codec LR clock; 1 = left slot.
REQ-014 SHALL have AUD_DACDAT  output  1  codec serial data.

Function
REQ-015 SHALL keep a divider counting 0..BCLK_HALF-1; at BCLK_HALF-1 it wraps to 0 and AUD_BCLK toggles, giving a BCLK period of 2*BCLK_HALF Clk.
REQ-016 SHALL treat a toggle from 1 to 0 as a falling event; bit_cnt advances modulo 2*SLOT_BITS only on falling events.
REQ-017 SHALL register all codec outputs, changing only on the falling-event Clk edge, so the codec samples DACDAT on the BCLK rising edge.
REQ-018 SHALL load the frame when bit_cnt becomes 0, during which frame_start=1, AUD_DACLRCK=1 and DACDAT=L[15].
REQ-019 SHALL set AUD_DACLRCK=0 and DACDAT=R[15] when bit_cnt becomes SLOT_BITS.
REQ-020 SHALL use left-justified, MSB-first format: slot position p gives DACDAT=sample[15-p] for p<16, else 0.
REQ-021 SHALL have a one-entry holding buffer, with in_ready = buffer empty (registered; no combinational path from in_valid).
REQ-022 SHALL, at a frame load with the buffer full, move the buffer into the shift registers and last-sample registers, so the buffer empties and in_ready=1 on the next Clk.
REQ-023 SHALL, at a frame load with the buffer empty, replay the last-sample registers and set underrun.
REQ-024 SHALL, if a transfer occurs in the same Clk as a frame load with the buffer empty, count it as an underrun; the new sample stays buffered for the next frame, with no bypass.
REQ-025 SHALL keep underrun set when clear_underrun coincides with a new underrun event (set wins).
REQ-026 SHALL produce a frame period of exactly 4*SLOT_BITS*BCLK_HALF Clk (defaults: 1024 Clk = 48.83 kHz at 50 MHz).

Reset
REQ-027 SHALL, in the Clk after Reset high, drive AUD_BCLK=0, AUD_DACLRCK=0, AUD_DACDAT=0, frame_start=0, underrun=0 and in_ready=1.
REQ-028 SHALL reset the divider to 0, bit_cnt to 2*SLOT_BITS-1, the shift and last-sample registers to 0, and the buffer to empty, discarding any held sample.
REQ-029 SHALL make the first falling event, and the first frame load, occur 2*BCLK_HALF Clk after Reset deasserts.
REQ-030 SHALL treat a mid-frame Reset identically, with no partial-frame completion.

Verification (BCLK_HALF=2, SLOT_BITS=16 unless stated)
REQ-031 SHALL check that after Reset, with no input, BCLK rises at cycle 2 and falls at cycle 4, frame_start pulses at cycle 4, underrun=1 from cycle 5, and DACDAT stays 0.
REQ-032 SHALL check that writing L=16'hA5C3, R=16'h8001 before the first load gives LRCK=1 for 16 BCLK with bits 1010010111000011, then LRCK=0 with 1000000000000001, and a frame period of 128 Clk.
REQ-033 SHALL check that with no new sample for frame 2, frame 2 repeats A5C3/8001 and underrun stays 1 until a clear_underrun pulse, then reads 0.
REQ-034 SHALL check that two back-to-back writes leave in_ready=0 after the first, the second accepted only after frame_start with in_ready=1 one Clk later, and the frames output in order.
REQ-035 SHALL check that with SLOT_BITS=32, bits 16..31 of each slot are 0, the frame is 256 Clk, and the LRCK toggle falls at the 32nd BCLK.
REQ-036 SHALL check that Reset asserted at the 5th bit of the left slot gives BCLK/LRCK/DACDAT=0 next Clk, the buffer is dropped, and the restart obeys REQ-029.
